serial_frame_tx: RTL and testbench

Serial frame transmitter: captures a WIDTH-bit word on a load/ready handshake and shifts it out on one line as start bit, data LSB-first, optional even parity, stop bit. Each bit is held for CLKS_PER_BIT clocks. It is the sending end of the capture path built from our level-sensitive storage cells: the latch side holds the word, and this block releases it serially. All state is registered on one clock, with asynchronous active-low reset.

---
 rtl/serial_frame_tx.sv | 172 +++++++++++++++++
 tb/tb_serial_frame_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_frame_tx
// Brief    : Serial frame transmitter: start bit, WIDTH data bits LSB-first,
//            optional even parity (SERIAL_FRAME_TX_PARITY_EN), stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT + 1);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] c_div_last = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_bit_last = CNT_W'(WIDTH - 1);

`ifdef SERIAL_FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_t;
`endif

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt;
  logic [CNT_W-1:0] r_bit,   w_bit_nxt;
  logic [DIV_W-1:0] r_div,   w_div_nxt;
  logic             w_tick;
  logic             w_sout_nxt;
  logic             w_done_nxt;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  logic             r_parity, w_parity_nxt;
`endif

  // Outputs are registered from the next-state values so they change on the
  // same edge as the state and never depend combinationally on load/din.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_bit    <= '0;
      r_div    <= '0;
      ready    <= 1'b1;
      sout     <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bit    <= w_bit_nxt;
      r_div    <= w_div_nxt;
      ready    <= (w_state_nxt == S_IDLE);
      busy     <= (w_state_nxt != S_IDLE);
      sout     <= w_sout_nxt;
      done     <= w_done_nxt;
`ifdef SERIAL_FRAME_TX_PARITY_EN
      r_parity <= w_parity_nxt;
`endif
    end
  end

  assign w_tick = (r_div == c_div_last);

  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bit_nxt    = r_bit;
    w_div_nxt    = r_div;
    w_done_nxt   = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    w_parity_nxt = r_parity;
`endif
    case (r_state)
      S_IDLE: begin
        if (load && ready) begin
          w_shift_nxt  = din;
          w_bit_nxt    = '0;
          w_div_nxt    = '0;
          w_state_nxt  = S_START;
`ifdef SERIAL_FRAME_TX_PARITY_EN
          w_parity_nxt = ^din;
`endif
        end
      end
      S_START: begin
        if (w_tick) begin
          w_div_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_div_nxt   = '0;
          w_shift_nxt = r_shift >> 1;
          if (r_bit == c_bit_last) begin
            w_bit_nxt   = '0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + CNT_W'(1);
          end
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY: begin
        if (w_tick) begin
          w_div_nxt   = '0;
          w_state_nxt = S_STOP;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_tick) begin
          w_div_nxt   = '0;
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_div_nxt = r_div + DIV_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_sout_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_sout_nxt = 1'b0;
      S_DATA:   w_sout_nxt = w_shift_nxt[0];
`ifdef SERIAL_FRAME_TX_PARITY_EN
      S_PARITY: w_sout_nxt = w_parity_nxt;
`endif
      default:  w_sout_nxt = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_frame_tx
// Brief    : Self-checking bench for serial_frame_tx against a bit-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_frame_tx;

  localparam int W = 8;
  localparam int C = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int NB = W + 3;
`else
  localparam int NB = W + 2;
`endif
  localparam int F = NB * C;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load;
  logic [W-1:0] din;
  logic         ready, sout, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .din   (din),
    .ready (ready),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  // Expected line level k clocks after acceptance: frame is a list of bits
  // (start, data LSB-first, [parity], stop), each lasting C clocks.
  function automatic logic model_bit(input logic [W-1:0] word, input int k);
    logic bits [NB];
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[1+i] = word[i];
`ifdef SERIAL_FRAME_TX_PARITY_EN
    bits[W+1] = ^word;
`endif
    bits[NB-1] = 1'b1;
    return bits[k / C];
  endfunction

  task automatic test_reset();
    rst_n = 1'b1; load = 1'b0; din = '0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (sout !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async sout=%b ready=%b busy=%b done=%b, want 1 1 0 0", sout, ready, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (sout !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle sout=%b ready=%b busy=%b done=%b, want 1 1 0 0", sout, ready, busy, done);
    end
  endtask

  task automatic test_single_frame(input logic [W-1:0] word);
    @(negedge clk); load = 1'b1; din = word;
    @(posedge clk); #1; load = 1'b0; din = ~word;
    for (int k = 0; k < F; k++) begin
      n_cmp++;
      if (sout !== model_bit(word, k) || busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL frame_%h k=%0d sout=%b busy=%b ready=%b done=%b, want sout=%b busy=1 ready=0 done=0",
                 word, k, sout, busy, ready, done, model_bit(word, k));
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (done !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || sout !== 1'b1) begin
      n_err++;
      $display("FAIL done_%h done=%b ready=%b busy=%b sout=%b, want 1 1 0 1", word, done, ready, busy, sout);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL done_drop_%h done=%b ready=%b, want 0 1", word, done, ready);
    end
  endtask

  task automatic test_ignore_busy();
    logic [W-1:0] word = W'(8'h0F);
    @(negedge clk); load = 1'b1; din = word;
    @(posedge clk); #1; load = 1'b0;
    for (int k = 0; k < F; k++) begin
      if (k == 10) begin load = 1'b1; din = W'(8'hFF); end
      if (k == F - 3) load = 1'b0;
      n_cmp++;
      if (sout !== model_bit(word, k) || busy !== 1'b1) begin
        n_err++;
        $display("FAIL ignore_busy k=%0d sout=%b busy=%b, want sout=%b busy=1", k, sout, busy, model_bit(word, k));
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL ignore_busy_done done=%b, want 1", done);
    end
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++;
      if (ready !== 1'b1 || busy !== 1'b0 || sout !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL ignore_busy_no_second ready=%b busy=%b sout=%b done=%b, want 1 0 1 0", ready, busy, sout, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w1 = W'(8'h01);
    logic [W-1:0] w2 = W'(8'h80);
    @(negedge clk); load = 1'b1; din = w1;
    @(posedge clk); #1;
    for (int k = 0; k < F; k++) begin
      if (k == 5) din = w2;
      n_cmp++;
      if (sout !== model_bit(w1, k) || busy !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_first k=%0d sout=%b busy=%b, want sout=%b busy=1", k, sout, busy, model_bit(w1, k));
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done1 done=%b ready=%b, want 1 1", done, ready);
    end
    @(posedge clk); #1; load = 1'b0;
    for (int k = 0; k < F; k++) begin
      n_cmp++;
      if (sout !== model_bit(w2, k) || busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_second k=%0d sout=%b busy=%b done=%b, want sout=%b busy=1 done=0",
                 k, sout, busy, done, model_bit(w2, k));
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done2 done=%b ready=%b, want 1 1", done, ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    logic [W-1:0] w1 = W'($urandom);
    logic [W-1:0] w2 = W'($urandom);
    @(negedge clk); load = 1'b1; din = w1;
    @(posedge clk); #1; load = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (sout !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_async sout=%b ready=%b busy=%b done=%b, want 1 1 0 0", sout, ready, busy, done);
    end
    @(negedge clk); load = 1'b1; din = w2;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0 || sout !== 1'b1 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_hold done=%b sout=%b ready=%b, want 0 1 1", done, sout, ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1; load = 1'b0;
    for (int k = 0; k < F; k++) begin
      n_cmp++;
      if (sout !== model_bit(w2, k) || busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL abort_refrm k=%0d sout=%b busy=%b done=%b, want sout=%b busy=1 done=0",
                 k, sout, busy, done, model_bit(w2, k));
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_refrm_done done=%b ready=%b, want 1 1", done, ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      test_single_frame(W'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_single_frame(W'(8'hA5));
    test_single_frame(W'(8'h07));
    test_single_frame(W'(8'h03));
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
